// File: rtl/gf2_poly_div_36bit.sv
// Bit-serial GF(2)[x] divider: 71-bit dividend by 36-bit divisor, normalise then long-divide.
// Define GF2DIV_QUOTIENT_EN to build the quotient register; otherwise quotient is tied to 0.
module gf2_poly_div_36bit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [70:0] i_dividend,
  input  logic [35:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [70:0] o_quotient,
  output logic [35:0] o_remainder,
  output logic        o_div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_DIV, S_DONE} state_t;

  state_t      r_state;
  logic [70:0] r_dvd;
  logic [35:0] r_dvs;
  logic [35:0] r_mask;
  logic [35:0] r_rem;
  logic [6:0]  r_step;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;

  logic        w_accept;
  logic [35:0] w_t;
  logic        w_qbit;
  logic [35:0] w_rem_nxt;

  assign w_accept = (r_state == S_IDLE) && i_start;

  // Remainder stays below x^d, so bit 36 of {r,bit} is always zero and is dropped.
  assign w_t       = {r_rem[34:0], r_dvd[70]};
  assign w_qbit    = |(w_t & r_mask);
  assign w_rem_nxt = w_qbit ? (w_t ^ r_dvs) : w_t;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_mask  <= '0;
      r_rem   <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_dvd   <= i_dividend;
            r_dvs   <= i_divisor;
            r_mask  <= 36'h8_0000_0000;
            r_rem   <= '0;
            r_step  <= 7'd70;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          // A zero divisor spends exactly one cycle here so done lands one edge after accept.
          if (r_dvs == '0) begin
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (|(r_dvs & r_mask)) begin
            r_state <= S_DIV;
          end else begin
            r_mask <= r_mask >> 1;
          end
        end
        S_DIV: begin
          r_rem  <= w_rem_nxt;
          r_dvd  <= r_dvd << 1;
          r_step <= r_step - 7'd1;
          if (r_step == 7'd0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef GF2DIV_QUOTIENT_EN
  logic [70:0] r_quo;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_quo <= '0;
    else if (w_accept)
      r_quo <= '0;
    else if (r_state == S_DIV)
      r_quo <= {r_quo[69:0], w_qbit};
  end

  assign o_quotient = r_quo;
`else
  assign o_quotient = '0;
`endif

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_gf2_poly_div_36bit.sv
// Randomised self-checking bench for gf2_poly_div_36bit against a long-division reference model.
module tb_gf2_poly_div_36bit;

`ifdef GF2DIV_QUOTIENT_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [70:0] dividend;
  logic [35:0] divisor;
  logic        busy;
  logic        done;
  logic [70:0] quotient;
  logic [35:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  gf2_poly_div_36bit dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy), .o_done(done), .o_quotient(quotient), .o_remainder(remainder),
    .o_div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Schoolbook polynomial long division over GF(2).
  function automatic void ref_div(input logic [70:0] a, input logic [35:0] b,
                                  output logic [70:0] q, output logic [35:0] r, output int d);
    logic [70:0] w;
    w = a; q = '0; d = 0;
    for (int i = 0; i < 36; i++) if (b[i]) d = i;
    for (int i = 70; i >= d; i--)
      if (w[i]) begin
        q[i-d] = 1'b1;
        w = w ^ (71'(b) << (i - d));
      end
    r = w[35:0];
  endfunction

  function automatic logic [70:0] clmul(input logic [70:0] q, input logic [35:0] b);
    logic [70:0] p;
    p = '0;
    for (int i = 0; i < 71; i++) if (q[i]) p = p ^ (71'(b) << i);
    return p;
  endfunction

  // Runs one operation; lat counts edges from accept to done (or to the reset edge).
  task automatic do_op(input logic [70:0] a, input logic [35:0] b, input int inj_edge,
                       input int rst_edge, output int lat, output bit got_done, output bit busy_ok);
    busy_ok = 1'b1; got_done = 1'b0; lat = 0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = ~a; divisor = ~b;
    for (int e = 1; e <= 200 && !got_done; e++) begin
      if (e == inj_edge) begin start = 1'b1; dividend = 71'h1F; divisor = 36'h7; end
      else start = 1'b0;
      rst = (e == rst_edge);
      @(posedge clk);
      @(negedge clk);
      lat = e;
      if (e == rst_edge) return;
      if (!busy) busy_ok = 1'b0;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = '1; divisor = 36'h3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs busy=%b done=%b q=%h r=%h dbz=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle busy=%b expected 0", busy); end
  endtask

  task automatic test_d1(input int inj_edge, input string tag);
    int lat; bit gd, bok;
    do_op(71'h5, 36'h3, inj_edge, -1, lat, gd, bok);
    n_checks++;
    if (gd !== 1'b1 || lat != 106) begin
      n_errors++; $display("FAIL %s_latency done=%b lat=%0d expected 106", tag, gd, lat);
    end
    n_checks++;
    if (quotient !== (QEN ? 71'h3 : 71'h0) || remainder !== 36'h0 || div_by_zero !== 1'b0) begin
      n_errors++; $display("FAIL %s_result q=%h r=%h dbz=%b", tag, quotient, remainder, div_by_zero);
    end
    n_checks++;
    if (bok !== 1'b1) begin n_errors++; $display("FAIL %s_busy busy dropped before done", tag); end
  endtask

  task automatic test_d35_and_done_start();
    int lat; bit gd, bok;
    do_op('1, 36'h8_0000_0000, -1, -1, lat, gd, bok);
    n_checks++;
    if (gd !== 1'b1 || lat != 72) begin
      n_errors++; $display("FAIL d35_latency done=%b lat=%0d expected 72", gd, lat);
    end
    n_checks++;
    if (quotient !== (QEN ? 71'h0F_FFFF_FFFF : 71'h0) || remainder !== 36'h7_FFFF_FFFF) begin
      n_errors++; $display("FAIL d35_result q=%h r=%h", quotient, remainder);
    end
    start = 1'b1; dividend = 71'h5; divisor = 36'h3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL start_on_done busy=%b done=%b expected 0 0", busy, done);
    end
    n_checks++;
    if (remainder !== 36'h7_FFFF_FFFF) begin
      n_errors++; $display("FAIL hold_result r=%h expected 7ffffffff", remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat; bit gd, bok;
    do_op(71'h1234, 36'h0, -1, -1, lat, gd, bok);
    n_checks++;
    if (gd !== 1'b1 || lat != 1 || div_by_zero !== 1'b1 || quotient !== '0 || remainder !== '0) begin
      n_errors++;
      $display("FAIL div_zero done=%b lat=%0d dbz=%b q=%h r=%h expected lat 1 dbz 1", gd, lat,
               div_by_zero, quotient, remainder);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (div_by_zero !== 1'b1 || done !== 1'b0) begin
      n_errors++; $display("FAIL dbz_hold dbz=%b done=%b expected 1 0", div_by_zero, done);
    end
    do_op(71'h11, 36'h3, -1, -1, lat, gd, bok);
    n_checks++;
    if (div_by_zero !== 1'b0 || remainder !== 36'h0) begin
      n_errors++; $display("FAIL dbz_clear dbz=%b r=%h expected 0 0", div_by_zero, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit gd, bok, seen;
    do_op(71'h5, 36'h3, -1, 40, lat, gd, bok);
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs busy=%b done=%b q=%h r=%h dbz=%b", busy, done, quotient,
               remainder, div_by_zero);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (120) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL reset_mid_abort activity after reset"); end
    do_op(71'h11, 36'h3, -1, -1, lat, gd, bok);
    n_checks++;
    if (gd !== 1'b1 || lat != 106 || quotient !== (QEN ? 71'hF : 71'h0) || remainder !== '0) begin
      n_errors++;
      $display("FAIL reset_recover lat=%0d q=%h r=%h expected 106 q=f r=0", lat, quotient, remainder);
    end
  endtask

  task automatic test_random(input int n);
    int lat, d; bit gd, bok;
    logic [70:0] a, q;
    logic [35:0] b, r;
    for (int k = 0; k < n; k++) begin
      d = $urandom_range(0, 35);
      b = {$urandom, $urandom};
      b = (b & ((36'(1) << d) - 36'd1)) | (36'(1) << d);
      a = {$urandom, $urandom, $urandom};
      if (k % 8 == 0) a = a >> $urandom_range(36, 70);
      ref_div(a, b, q, r, d);
      do_op(a, b, -1, -1, lat, gd, bok);
      n_checks++;
      if (gd !== 1'b1 || lat != 107 - d || bok !== 1'b1) begin
        n_errors++;
        $display("FAIL rand_timing a=%h b=%h done=%b lat=%0d expected %0d busy_ok=%b", a, b, gd,
                 lat, 107 - d, bok);
      end
      n_checks++;
      if (remainder !== r || quotient !== (QEN ? q : 71'h0) || div_by_zero !== 1'b0) begin
        n_errors++;
        $display("FAIL rand_result a=%h b=%h q=%h r=%h expected q=%h r=%h", a, b, quotient,
                 remainder, QEN ? q : 71'h0, r);
      end
      n_checks++;
      if ((remainder >> d) !== 36'h0) begin
        n_errors++; $display("FAIL rand_rem_degree r=%h d=%0d", remainder, d);
      end
`ifdef GF2DIV_QUOTIENT_EN
      n_checks++;
      if ((clmul(quotient, b) ^ 71'(remainder)) !== a) begin
        n_errors++; $display("FAIL rand_identity a=%h q=%h r=%h", a, quotient, remainder);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_d1(-1, "d1");
    test_d35_and_done_start();
    test_div_zero();
    test_d1(10, "ignored_start");
    test_reset_mid();
    test_random(300);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
